// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - Arbitrates I-side and D-side cache line traffic onto one physical-memory port.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]   state;
  logic         last_grant_d;
  logic         resp_d;
  logic         wflag;
  logic [26:0]  line_q;
  logic [255:0] wdata_q;
  logic [255:0] rdata_q;
  logic         i_pend;
  logic         d_pend;
  logic         grant_d;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  // On a tie the side that did not win the previous grant goes first.
  assign grant_d = d_pend & (~i_pend | ~last_grant_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      resp_d       <= 1'b0;
      wflag        <= 1'b0;
      line_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_pend | d_pend) begin
            last_grant_d <= grant_d;
            if (grant_d) begin
              line_q  <= d_address[31:5];
              wflag   <= d_write;
              wdata_q <= d_wdata;
              state   <= D_BUSY;
            end else begin
              line_q  <= i_address[31:5];
              wflag   <= 1'b0;
              wdata_q <= '0;
              state   <= I_BUSY;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          if (pmem_resp) begin
            rdata_q <= pmem_rdata;
            resp_d  <= (state == D_BUSY);
            state   <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs come only from registered state so requester churn cannot leak through.
  assign pmem_read    = (state == I_BUSY) | ((state == D_BUSY) & ~wflag);
  assign pmem_write   = (state == D_BUSY) & wflag;
  assign pmem_address = {line_q, 5'b0};
  assign pmem_wdata   = wdata_q;

  assign i_resp  = (state == RESP) & ~resp_d;
  assign d_resp  = (state == RESP) & resp_d;
  assign i_rdata = rdata_q;
  assign d_rdata = rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - Scoreboard bench for cache_arbiter with a transaction-level reference model.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata;
  logic [255:0] i_rdata, d_rdata;
  logic         i_resp, d_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed { bit wr; logic [31:0] addr; logic [255:0] wdata; } pm_t;
  typedef struct packed { bit is_d; logic [255:0] rdata; } rs_t;

  pm_t exp_pm[$];
  rs_t exp_rs[$];
  logic [255:0] mem_ref [logic [26:0]];
  logic [255:0] mem_pm  [logic [26:0]];
  bit   last_d_ref;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_on = 0;
  bit   pm_auto = 1;
  int   pm_lat = -1;
  logic [31:0] last_pm_addr;
  bit   last_pm_wr;

  task automatic ck(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [26:0] ln);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = {5'b0, ln} * 32'h9E37_79B9 + k;
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Memory returns the inverted write line as read data on a write completion.
  function automatic void model_push(input bit is_d, input bit wr, input logic [31:0] addr,
                                     input logic [255:0] wdata);
    pm_t p;
    rs_t r;
    logic [26:0] ln;
    ln = addr[31:5];
    p.wr = wr;
    p.addr = addr & 32'hFFFF_FFE0;
    p.wdata = wdata;
    r.is_d = is_d;
    if (wr) begin
      mem_ref[ln] = wdata;
      r.rdata = ~wdata;
    end else begin
      r.rdata = mem_ref.exists(ln) ? mem_ref[ln] : init_line(ln);
    end
    exp_pm.push_back(p);
    exp_rs.push_back(r);
    last_d_ref = is_d;
  endfunction

  function automatic void model_issue(input bit do_i, input logic [31:0] ia, input bit do_d,
                                      input bit dwr, input logic [31:0] da, input logic [255:0] dwd);
    if (do_i && do_d) begin
      if (!last_d_ref) begin
        model_push(1'b1, dwr, da, dwd);
        model_push(1'b0, 1'b0, ia, '0);
      end else begin
        model_push(1'b0, 1'b0, ia, '0);
        model_push(1'b1, dwr, da, dwd);
      end
    end else if (do_i) begin
      model_push(1'b0, 1'b0, ia, '0);
    end else if (do_d) begin
      model_push(1'b1, dwr, da, dwd);
    end
  endfunction

  // Physical memory: responds after pm_lat busy cycles (random when negative).
  initial begin
    int busy_cnt;
    int cur_lat;
    logic [26:0] ln;
    busy_cnt = 0;
    cur_lat = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pm_auto) begin
        if (pmem_resp) begin
          pmem_resp = 1'b0;
          busy_cnt = 0;
        end else if (pmem_read || pmem_write) begin
          if (busy_cnt == 0) cur_lat = (pm_lat >= 0) ? pm_lat : $urandom_range(0, 4);
          if (busy_cnt == cur_lat) begin
            ln = pmem_address[31:5];
            if (pmem_write) begin
              mem_pm[ln] = pmem_wdata;
              pmem_rdata = ~pmem_wdata;
            end else begin
              pmem_rdata = mem_pm.exists(ln) ? mem_pm[ln] : init_line(ln);
            end
            pmem_resp = 1'b1;
          end
          busy_cnt++;
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Monitor: compares memory-side transactions and completions against the scoreboard queues.
  initial begin
    bit prev_strobe, resp_due, strobe;
    pm_t cur, held;
    rs_t r;
    prev_strobe = 0;
    resp_due = 0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_on) begin
        strobe = pmem_read | pmem_write;
        ck(!(pmem_read && pmem_write), "pmem_rw_exclusive", {pmem_read, pmem_write}, 0);
        ck(!(i_resp && d_resp), "resp_exclusive", {i_resp, d_resp}, 0);
        if (i_resp || d_resp) begin
          ck(resp_due, "resp_timing", {i_resp, d_resp}, 0);
          if (exp_rs.size() == 0) begin
            ck(1'b0, "resp_unexpected", {i_resp, d_resp}, 0);
          end else begin
            r = exp_rs.pop_front();
            ck(d_resp == r.is_d, "resp_side", {i_resp, d_resp}, {~r.is_d, r.is_d});
            ck(i_rdata == r.rdata, "i_rdata", i_rdata, r.rdata);
            ck(d_rdata == r.rdata, "d_rdata", d_rdata, r.rdata);
          end
        end else if (resp_due) begin
          ck(1'b0, "resp_missing", 0, 1);
        end
        if (strobe && !prev_strobe) begin
          if (exp_pm.size() == 0) begin
            ck(1'b0, "pmem_unexpected", pmem_address, 0);
          end else begin
            cur = exp_pm.pop_front();
            ck(pmem_write == cur.wr, "pmem_write", pmem_write, cur.wr);
            ck(pmem_read == !cur.wr, "pmem_read", pmem_read, !cur.wr);
            ck(pmem_address == cur.addr, "pmem_address", pmem_address, cur.addr);
            if (cur.wr) ck(pmem_wdata == cur.wdata, "pmem_wdata", pmem_wdata, cur.wdata);
          end
          held.wr = pmem_write;
          held.addr = pmem_address;
          held.wdata = pmem_wdata;
          last_pm_addr = pmem_address;
          last_pm_wr = pmem_write;
        end else if (strobe) begin
          ck(pmem_address == held.addr, "pmem_address_stable", pmem_address, held.addr);
          ck(pmem_wdata == held.wdata, "pmem_wdata_stable", pmem_wdata, held.wdata);
          ck(pmem_write == held.wr, "pmem_write_stable", pmem_write, held.wr);
        end
        resp_due = strobe && pmem_resp && !rst;
        prev_strobe = strobe;
      end
    end
  end

  task automatic run_round(input bit do_i, input logic [31:0] ia, input bit do_d, input bit dwr,
                           input bit dboth, input logic [31:0] da, input logic [255:0] dwd,
                           input bit churn, input bit drop, input int exp_first);
    int n, first;
    bit wi, wd;
    @(negedge clk);
    i_read = do_i;
    i_address = ia;
    d_read = do_d & (~dwr | dboth);
    d_write = do_d & dwr;
    d_address = da;
    d_wdata = dwd;
    model_issue(do_i, ia, do_d, dwr, da, dwd);
    wi = do_i;
    wd = do_d;
    n = 0;
    first = -1;
    while ((wi || wd) && n < 100) begin
      @(negedge clk);
      n++;
      if (wi && i_resp) begin wi = 0; i_read = 0; if (first < 0) first = n; end
      if (wd && d_resp) begin wd = 0; d_read = 0; d_write = 0; if (first < 0) first = n; end
      if (drop && n == 1) begin i_read = 0; d_read = 0; d_write = 0; end
      if (churn || !wi) i_address = $urandom;
      if (churn || !wd) begin d_address = $urandom; d_wdata = rand256(); end
    end
    ck(!(wi || wd), "round_timeout", {wi, wd}, 0);
    if (exp_first >= 0) ck(first == exp_first, "resp_latency", first, exp_first);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    i_read = 0; d_read = 0; d_write = 0;
    i_address = 0; d_address = 0; d_wdata = 0;
    last_d_ref = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    ck(pmem_read == 0, "reset_pmem_read", pmem_read, 0);
    ck(pmem_write == 0, "reset_pmem_write", pmem_write, 0);
    ck(i_resp == 0 && d_resp == 0, "reset_resp", {i_resp, d_resp}, 0);
    ck(i_rdata == 0, "reset_rdata", i_rdata, 0);
    ck(pmem_address == 0, "reset_address", pmem_address, 0);
    ck(pmem_wdata == 0, "reset_wdata", pmem_wdata, 0);
    mon_on = 1;

    // Ties after reset: D, then I, then D again.
    run_round(1, 32'h0000_0400, 1, 0, 0, 32'h0000_0800, '0, 0, 0, -1);
    run_round(1, 32'h0000_0440, 1, 0, 0, 32'h0000_0840, '0, 0, 0, -1);

    pm_lat = 3;
    run_round(1, 32'h0000_1234, 0, 0, 0, 32'h0, '0, 0, 0, 5);
    ck(last_pm_addr == 32'h0000_1220, "i_read_address", last_pm_addr, 32'h0000_1220);
    pm_lat = 2;
    run_round(0, 32'h0, 1, 1, 0, 32'h8000_003F, {8{32'hC0DE_F00D}}, 0, 0, 4);
    ck(last_pm_addr == 32'h8000_0020 && last_pm_wr, "d_write_address",
       {last_pm_wr, last_pm_addr}, {1'b1, 32'h8000_0020});
    run_round(0, 32'h0, 1, 0, 0, 32'h8000_0020, '0, 0, 0, 4);

    // Minimum latency back to back, then a read+write collision treated as write.
    pm_lat = 0;
    run_round(1, 32'h0000_2000, 0, 0, 0, 32'h0, '0, 0, 0, 2);
    run_round(0, 32'h0, 1, 0, 0, 32'h0000_3000, '0, 0, 0, 2);
    run_round(0, 32'h0, 1, 1, 1, 32'h0000_3010, rand256(), 0, 0, 2);

    pm_lat = 3;
    run_round(1, 32'h0000_2040, 0, 0, 0, 32'h0, '0, 1, 1, 5);
    run_round(0, 32'h0, 1, 1, 0, 32'h0000_5000, rand256(), 1, 0, 5);

    // Reset in the middle of a D transaction; the late pmem_resp must be ignored.
    pm_auto = 0;
    @(negedge clk);
    d_read = 1;
    d_address = 32'h4000_0100;
    model_issue(0, 32'h0, 1, 0, 32'h4000_0100, '0);
    @(negedge clk);
    ck(pmem_read == 1, "rst_test_busy", pmem_read, 1);
    @(negedge clk);
    rst = 1;
    d_read = 0;
    @(negedge clk);
    rst = 0;
    exp_rs.delete();
    last_d_ref = 0;
    ck(pmem_read == 0 && pmem_write == 0, "rst_strobes", {pmem_read, pmem_write}, 0);
    ck(d_rdata == 0, "rst_rdata", d_rdata, 0);
    pmem_resp = 1;
    @(negedge clk);
    pmem_resp = 0;
    repeat (4) begin
      ck(!d_resp && !i_resp, "rst_no_resp", {i_resp, d_resp}, 0);
      ck(!pmem_read && !pmem_write, "rst_idle", {pmem_read, pmem_write}, 0);
      @(negedge clk);
    end
    pm_auto = 1;
    run_round(1, 32'h0000_0600, 1, 1, 0, 32'h0000_0A00, rand256(), 0, 0, -1);

    pm_lat = -1;
    for (int r = 0; r < 300; r++) begin
      int kind;
      bit dwr, dboth, ch;
      logic [31:0] ia, da;
      kind = $urandom_range(0, 2);
      dwr = $urandom_range(0, 1);
      dboth = dwr && ($urandom_range(0, 3) == 0);
      ch = (kind != 2) && $urandom_range(0, 1);
      ia = 32'h1000_0000 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
      da = 32'h1000_0000 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
      run_round(kind != 1, ia, kind != 0, dwr, dboth, da, rand256(), ch, 0, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    ck(exp_pm.size() == 0, "pmem_queue_drained", exp_pm.size(), 0);
    ck(exp_rs.size() == 0, "resp_queue_drained", exp_rs.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
